// File: rtl/reservoir_mem_arbiter.sv
// Port-B arbiter for the reservoir output memory.
// r0 (reservoir history writer) always wins; r1 (matrix-multiplier reader) and
// r2 (host debug port) share the remaining cycles round-robin. Memory port
// signals are registered, and read returns are steered back to their requester
// through a tag pipeline whose length matches the BRAM read latency.
module reservoir_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 17,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,

  // Reservoir writer (write-only, never stalled)
  input  logic                  r0_valid,
  output logic                  r0_ready,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,

  // Matrix-multiplier reader (read-only)
  input  logic                  r1_valid,
  output logic                  r1_ready,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,

  // Host debug port (read or write)
  input  logic                  r2_valid,
  output logic                  r2_ready,
  input  logic                  r2_we,
  input  logic [ADDR_WIDTH-1:0] r2_addr,
  input  logic [DATA_WIDTH-1:0] r2_wdata,
  output logic                  r2_rvalid,
  output logic [DATA_WIDTH-1:0] r2_rdata,

  input  logic                  host_block,

  // BRAM port B
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_dout,

  output logic [15:0]           stall_cnt
);

  // One stage for the registered address plus READ_LATENCY stages inside the BRAM.
  localparam int unsigned TagDepth = 1 + READ_LATENCY;

  // Tag id encoding for read requesters.
  localparam logic IdR1 = 1'b0;
  localparam logic IdR2 = 1'b1;

  logic                  rr_q, rr_d;
  logic                  r2_eligible;
  logic                  grant_r0, grant_r1, grant_r2;
  logic                  any_accept;
  logic                  read_accept;
  logic                  read_id;
  logic                  stall;

  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
  logic                  mem_we_q, mem_we_d;

  logic [TagDepth-1:0]   tag_valid_q, tag_valid_d;
  logic [TagDepth-1:0]   tag_id_q, tag_id_d;
  logic                  tag_out_valid;
  logic                  tag_out_id;

  logic [DATA_WIDTH-1:0] r1_rdata_q, r2_rdata_q;
  logic [15:0]           stall_cnt_q, stall_cnt_d;

  // Combinational grant: r0 first, then the r1/r2 pair resolved by rr on a tie.
  always_comb begin
    r2_eligible = r2_valid && !host_block;
    grant_r0    = r0_valid;
    grant_r1    = !r0_valid && r1_valid && (!r2_eligible || !rr_q);
    grant_r2    = !r0_valid && r2_eligible && (!r1_valid || rr_q);
    any_accept  = grant_r0 || grant_r1 || grant_r2;
    read_accept = grant_r1 || (grant_r2 && !r2_we);
    read_id     = grant_r2 ? IdR2 : IdR1;
    stall       = (r1_valid && !grant_r1) || (r2_valid && !grant_r2);

    // r0 is always accepted outside reset; during reset its request is dropped.
    r0_ready = !rst;
    r1_ready = grant_r1;
    r2_ready = grant_r2;
  end

  // Next-state for the round-robin pointer, memory port, tags and stall counter.
  always_comb begin
    rr_d       = rr_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;

    if (grant_r1) begin
      rr_d = 1'b1;
    end else if (grant_r2) begin
      rr_d = 1'b0;
    end

    if (grant_r0) begin
      mem_addr_d = r0_addr;
      mem_din_d  = r0_wdata;
      mem_we_d   = 1'b1;
    end else if (grant_r1) begin
      // Read-only requester: write data is left untouched.
      mem_addr_d = r1_addr;
    end else if (grant_r2) begin
      mem_addr_d = r2_addr;
      mem_din_d  = r2_wdata;
      mem_we_d   = r2_we;
    end

    tag_valid_d = {tag_valid_q[TagDepth-2:0], read_accept};
    tag_id_d    = {tag_id_q[TagDepth-2:0], read_id};

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  // State registers; reset clears everything, so accepts and in-flight reads are discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      mem_we_q    <= 1'b0;
      tag_valid_q <= '0;
      tag_id_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      rr_q        <= rr_d;
      mem_addr_q  <= mem_addr_d;
      mem_din_q   <= mem_din_d;
      mem_we_q    <= mem_we_d && any_accept;
      tag_valid_q <= tag_valid_d;
      tag_id_q    <= tag_id_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Tag pipeline output lines up with the BRAM data for the request that issued it.
  always_comb begin
    tag_out_valid = tag_valid_q[TagDepth-1];
    tag_out_id    = tag_id_q[TagDepth-1];
    r1_rvalid     = tag_out_valid && (tag_out_id == IdR1);
    r2_rvalid     = tag_out_valid && (tag_out_id == IdR2);
    r1_rdata      = r1_rvalid ? mem_dout : r1_rdata_q;
    r2_rdata      = r2_rvalid ? mem_dout : r2_rdata_q;
  end

  // Hold registers so each requester keeps its last returned word between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_rdata_q <= '0;
      r2_rdata_q <= '0;
    end else begin
      if (r1_rvalid) begin
        r1_rdata_q <= mem_dout;
      end
      if (r2_rvalid) begin
        r2_rdata_q <= mem_dout;
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_we    = mem_we_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/reservoir_mem_arbiter.md
# reservoir_mem_arbiter

Arbitrates port B of the reservoir output memory between three requesters: the reservoir history writer, the matrix-multiplier reader and a host debug port.
- The reservoir writer is real-time and is never stalled.
- The other two requesters share the remaining cycles round-robin.
- Memory port signals are registered, and each read return is steered back to the requester that issued it using a latency-matched tag pipeline.
- The block sits between the core datapath and the dual-port BRAM, replacing the ad-hoc address mux on port B.

## Interface
Parameters:
- ADDR_WIDTH, 17, memory address width
- DATA_WIDTH, 32, memory data width
- READ_LATENCY, 1, BRAM read latency in cycles (legal: 1 or 2)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- r0_valid / r0_ready  in / out  1 / 1  reservoir writer request / accept
- r0_addr / r0_wdata  in  ADDR_WIDTH / DATA_WIDTH  writer address / data (r0 is write-only)
- r1_valid / r1_ready  in / out  1 / 1  matrix-multiplier request / accept
- r1_addr  in  ADDR_WIDTH  read address (r1 is read-only)
- r1_rvalid / r1_rdata  out  1 / DATA_WIDTH  read return
- r2_valid / r2_ready / r2_we  in / out / in  1 / 1 / 1  host request / accept / write enable
- r2_addr / r2_wdata  in  ADDR_WIDTH / DATA_WIDTH  host address / data
- r2_rvalid / r2_rdata  out  1 / DATA_WIDTH  host read return
- host_block  in  1  core busy; forces r2_ready=0
- mem_addr / mem_din / mem_we  out  ADDR_WIDTH / DATA_WIDTH / 1  registered BRAM port B
- mem_dout  in  DATA_WIDTH  BRAM port B read data
- stall_cnt  out  16  saturating count of cycles in which any valid was not accepted

## Operation
- Grant is combinational, from the current valids and the round-robin pointer rr. Exactly one requester, or none, is accepted per cycle.
- r0_ready = 1 whenever rst=0. If r0_valid=1, r1_ready = r2_ready = 0.
- If r0_valid=0:
  - Only one of r1/r2 valid (r2 counts only when host_block=0): that requester is accepted.
  - Both valid: the requester selected by rr is accepted (rr=0 selects r1, rr=1 selects r2).
- rr update:
  - Set to 1 after an r1 accept and to 0 after an r2 accept.
  - Unchanged on an r0 accept or an idle cycle.
  - Reset value 0 (r1 favoured first).
- Accept at cycle T: on the rising edge ending T, mem_addr, mem_din and mem_we are registered from the winner.
  - mem_we = 1 for r0, and for r2 with r2_we=1.
  - With no accept, mem_we = 0 and mem_addr/mem_din hold their previous values.
- Read tag pipeline:
  - Each read accept pushes tag {valid, id}; writes and idle cycles push an invalid tag.
  - Depth is 1+READ_LATENCY.
  - At the pipeline output, the matching rX_rvalid pulses for one cycle and rX_rdata = mem_dout.
  - rdata for a requester holds its last value when its rvalid is 0.
- stall_cnt increments in every cycle where (r1_valid && !r1_ready) || (r2_valid && !r2_ready). It saturates at 16'hFFFF.
- No ordering hazard handling: a host write and a multiplier read to the same address in adjacent cycles resolve in BRAM order. This is acceptable, because host_block is asserted while the core runs.

## Timing
- Reset (rst=1 at the edge): mem_we=0, mem_addr=0, mem_din=0, r1_rvalid=r2_rvalid=0, r1_rdata=r2_rdata=0, rr=0, stall_cnt=0, all tags invalid.
- The readies follow the same grant logic during reset except r0_ready=0; any accept during reset is discarded.
- A read in flight when rst rises produces no rvalid after reset.
- Read latency from accept cycle T to rvalid is 1+READ_LATENCY cycles, so READ_LATENCY=1 gives rvalid in cycle T+2.
- Full throughput: one accept per cycle sustained. Back-to-back reads from alternating requesters return in issue order, one per cycle.
- host_block rising in the same cycle as r2_valid: r2 is not accepted in that cycle.
- Simultaneous r0/r1/r2 valid: r0 wins, and rr is unchanged. The pending r1/r2 tie is then resolved by rr in the next free cycle.

## Test plan
- Reset, then r1 reads 0x10 with BRAM model word[0x10]=0xDEADBEEF, READ_LATENCY=1 -> r1_ready=1 at T; mem_addr=0x10, mem_we=0 in T+1; r1_rvalid=1 with r1_rdata=0xDEADBEEF in T+2 only.
- r0 writes 0x5/0x1234 while r1 and r2 are both valid -> r0 accepted; r1_ready=r2_ready=0; stall_cnt +1; next cycle r1 accepted (rr=0); the cycle after, r2 accepted.
- r1 and r2 held valid for 6 cycles, no r0 -> accepts alternate r1,r2,r1,r2,r1,r2; stall_cnt = 6; returns alternate in the same order.
- host_block=1 with r2_valid=1 for 4 cycles, then host_block=0 -> r2_ready=0 for 4 cycles; stall_cnt = 4; r2 accepted in the first cycle after release.
- r1 read accepted, rst asserted the next cycle -> no r1_rvalid in any cycle after reset; all outputs at their reset values.
- stall_cnt preloaded by 65540 stall cycles -> holds 0xFFFF and does not wrap.
